// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key codes are {row[1:0], col[1:0]}, which equals the flat bit index row*4+col.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_DB,
        HELD,
        REL_DB
    } key_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_result_t;

    typedef struct packed {
        scan_result_t kind;
        key_code_t    code;
    } scan_t;

    // Classify one complete scan; bit index of a hit is directly its key code.
    function automatic scan_t classify(input logic [KP_ROWS*KP_COLS-1:0] hits);
        scan_t      res;
        logic [4:0] n;
        res.kind = SCAN_NONE;
        res.code = '0;
        n        = '0;
        for (int i = 0; i < KP_ROWS*KP_COLS; i++) begin
            if (hits[i]) begin
                n        = n + 5'd1;
                res.code = key_code_t'(i);
            end
        end
        if (n == 5'd1) begin
            res.kind = SCAN_SINGLE;
        end else if (n != 5'd0) begin
            res.kind = SCAN_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments let both flops sample their inputs on the same edge,
    // so the chain really is two stages deep regardless of statement order.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sampling, whole-scan debounce, valid/ready delivery.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 32
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [KP_COLS-1:0] col_i,
    output logic [KP_ROWS-1:0] row_o,
    output logic               key_valid,
    input  logic               key_ready,
    output key_code_t          key_code,
    output logic               overrun
);

    if (SETTLE_CYCLES < 4 || SETTLE_CYCLES > 255 || DEBOUNCE_SCANS < 1 ||
        DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB         = 4'(DEBOUNCE_SCANS);

    logic [KP_COLS-1:0]         col_sync;
    logic [1:0]                 row_q;
    logic [7:0]                 settle_q;
    logic [KP_ROWS*KP_COLS-1:0] hits_q;
    logic                       scan_done_q;
    logic                       last_settle;
    scan_t                      scan_res;

    key_state_t state_q, state_d;
    logic [3:0] count_q, count_d;
    key_code_t  cand_q, cand_d;
    logic       press_accept;
    logic       rep_accept;
    logic       accept;
    key_code_t  accept_code;
    logic       handshake;

    keypad_sync #(.WIDTH(KP_COLS)) u_col_sync (
        .clk  (clk),
        .nRst (nRst),
        .d    (col_i),
        .q    (col_sync)
    );

    // ---------------- scan engine ----------------
    assign last_settle = (settle_q == SETTLE_LAST);
    assign scan_res    = classify(hits_q);

    // NOTE: the hit matrix is only sixteen flops, so it is reset like any other state;
    // a scan straight after reset then sees stale-free data.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            row_q       <= '0;
            settle_q    <= '0;
            hits_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (last_settle) begin
                settle_q                             <= '0;
                row_q                                <= row_q + 2'd1;
                hits_q[row_q*KP_COLS +: KP_COLS]     <= col_sync;
                scan_done_q                          <= (row_q == 2'(KP_ROWS - 1));
            end else begin
                settle_q <= settle_q + 8'd1;
            end
        end
    end

    // ---------------- key FSM: state register ----------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= RELEASED;
            count_q <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cand_q  <= cand_d;
        end
    end

    // ---------------- key FSM: next state ----------------
    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cand_d       = cand_q;
        press_accept = 1'b0;
        if (scan_done_q) begin
            unique case (state_q)
                RELEASED: begin
                    if (scan_res.kind == SCAN_SINGLE) begin
                        cand_d  = scan_res.code;
                        count_d = 4'd1;
                        state_d = PRESS_DB;
                        if (count_d == DEB) begin
                            press_accept = 1'b1;
                            state_d      = HELD;
                            count_d      = '0;
                        end
                    end
                end
                PRESS_DB: begin
                    if (scan_res.kind == SCAN_SINGLE) begin
                        if (scan_res.code == cand_q) begin
                            count_d = count_q + 4'd1;
                        end else begin
                            cand_d  = scan_res.code;
                            count_d = 4'd1;
                        end
                        if (count_d == DEB) begin
                            press_accept = 1'b1;
                            state_d      = HELD;
                            count_d      = '0;
                        end
                    end else begin
                        state_d = RELEASED;
                        count_d = '0;
                    end
                end
                HELD: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        count_d = 4'd1;
                        state_d = REL_DB;
                        if (count_d == DEB) begin
                            state_d = RELEASED;
                            count_d = '0;
                        end
                    end
                end
                REL_DB: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        count_d = count_q + 4'd1;
                        if (count_d == DEB) begin
                            state_d = RELEASED;
                            count_d = '0;
                        end
                    end else begin
                        state_d = HELD;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);

    logic [REP_W-1:0] rep_q, rep_d;

    // Counts full scans spent in HELD; the acceptance scan itself does not count.
    always_comb begin
        rep_d      = rep_q;
        rep_accept = 1'b0;
        if (state_q != HELD || state_d != HELD) begin
            rep_d = '0;
        end else if (scan_done_q) begin
            if (rep_q == REP_W'(REPEAT_SCANS - 1)) begin
                rep_accept = 1'b1;
                rep_d      = '0;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_accept = 1'b0;
`endif

    // ---------------- key FSM: outputs ----------------
    always_comb begin
        row_o        = '0;
        row_o[row_q] = 1'b1;
        accept       = press_accept | rep_accept;
        accept_code  = press_accept ? cand_d : cand_q;
    end

    // ---------------- delivery handshake ----------------
    assign handshake = key_valid & key_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (accept && (!key_valid || handshake)) begin
                key_valid <= 1'b1;
                key_code  <= accept_code;
            end else if (handshake) begin
                key_valid <= 1'b0;
            end
            // A press landing in the same cycle as a handshake takes the freed slot.
            if (handshake) begin
                overrun <= 1'b0;
            end else if (accept && key_valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SETTLE 4, DEBOUNCE 2, REPEAT 3).
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN = 16;

    logic       clk       = 1'b0;
    logic       nRst      = 1'b0;
    logic       key_ready = 1'b0;
    logic [3:0] col_i;
    logic [3:0] row_o;
    logic       key_valid;
    logic [3:0] key_code;
    logic       overrun;
    logic [15:0] keys = '0;   // bit row*4+col = contact closed

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int n_del  = 0;
    int         del_cycle [256];
    logic [3:0] del_code  [256];

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .col_i     (col_i),
        .row_o     (row_o),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Membrane model: a closed contact connects the driven row to its column.
    always_comb begin
        col_i = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_o[r]) col_i = col_i | keys[r*4 +: 4];
        end
    end

    // Delivery monitor: a handshake is seen high at the negedge before the accepting edge.
    always @(negedge clk) begin
        if (nRst && key_valid && key_ready && n_del < 256) begin
            del_cycle[n_del] = cycle;
            del_code[n_del]  = key_code;
            n_del++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int k = 0;
        while (!key_valid && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
    endtask

    // Leaves the bench at the negedge in the first cycle of row 0.
    task automatic align_scan();
        int k = 0;
        while (row_o != 4'b1000 && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (row_o != 4'b0001 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("align_timeout", 32'(k < 100), 32'd1);
    endtask

    initial begin
        int n0;
        int t0;
        int bad;
        int gap;

        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t0;
        int bad;
        int gap;

        // Reset state
        wait_cycles(3);
        check("rst_row",   32'(row_o),     32'h1);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code",  32'(key_code),  32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        nRst = 1'b1;

        // Row sequence: four cycles per row, 0 -> 3
        align_scan();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (row_o != 4'(1 << (i / 4))) bad++;
            @(negedge clk);
        end
        check("row_seq_bad", 32'(bad), 32'd0);

        // Steady press row 2 / col 1 -> one delivery of 4'b1001
        key_ready = 1'b1;
        align_scan();
        n0 = n_del;
        t0 = cycle;
        keys[9] = 1'b1;
        wait_valid("press9", 80);
        check("press9_code", 32'(key_code), 32'h9);
        check("press9_lat", 32'((cycle - t0) inside {[31:35]}), 32'd1);
        wait_cycles(2 * SCAN);
        check("press9_once", 32'(n_del - n0), 32'd1);
        check("press9_clr",  32'(key_valid), 32'd0);
        keys = '0;
        wait_cycles(4 * SCAN);

        // Bounce: one-scan contact must not be delivered
        n0 = n_del;
        keys[6] = 1'b1;
        wait_cycles(SCAN);
        keys = '0;
        wait_cycles(5 * SCAN);
        check("bounce_none", 32'(n_del - n0), 32'd0);
        check("bounce_valid", 32'(key_valid), 32'd0);

        // Ghost: two keys -> MULTI, nothing; then 4'b1111 alone
        n0 = n_del;
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        wait_cycles(5 * SCAN);
        check("ghost_none", 32'(n_del - n0), 32'd0);
        keys[0] = 1'b0;
        wait_valid("ghost_f", 80);
        check("ghost_code", 32'(key_code), 32'hf);
        keys = '0;
        wait_cycles(4 * SCAN);

        // Overrun: consumer stalled across two presses
        key_ready = 1'b0;
        keys[3] = 1'b1;
        wait_valid("ovr3", 80);
        check("ovr3_code", 32'(key_code), 32'h3);
        check("ovr3_flag", 32'(overrun),  32'd0);
        keys = '0;
        wait_cycles(4 * SCAN);
        keys[12] = 1'b1;
        wait_cycles(4 * SCAN);
        check("ovr_valid", 32'(key_valid), 32'd1);
        check("ovr_code",  32'(key_code),  32'h3);
        check("ovr_flag",  32'(overrun),   32'd1);
        n0 = n_del;
        key_ready = 1'b1;
        @(negedge clk);
        keys = '0;
        check("ovr_ack_valid", 32'(key_valid), 32'd0);
        check("ovr_ack_flag",  32'(overrun),   32'd0);
        check("ovr_ack_count", 32'(n_del - n0), 32'd1);
        wait_cycles(4 * SCAN);

        // Reset during PRESS_DB with a pending key
        key_ready = 1'b0;
        keys[5] = 1'b1;
        wait_valid("pend5", 80);
        keys = '0;
        wait_cycles(4 * SCAN);
        align_scan();
        keys[6] = 1'b1;
        wait_cycles(20);
        #2 nRst = 1'b0;
        #1;
        check("arst_row",   32'(row_o),     32'h1);
        check("arst_valid", 32'(key_valid), 32'h0);
        check("arst_code",  32'(key_code),  32'h0);
        check("arst_ovr",   32'(overrun),   32'h0);
        @(negedge clk);
        keys      = '0;
        key_ready = 1'b1;
        nRst      = 1'b1;
        n0 = n_del;
        wait_cycles(5 * SCAN);
        check("arst_none",  32'(n_del - n0), 32'd0);
        check("arst_idle",  32'(key_valid),  32'd0);
        keys[6] = 1'b1;
        wait_valid("fresh6", 80);
        check("fresh6_code", 32'(key_code), 32'h6);
        keys = '0;
        wait_cycles(4 * SCAN);

        // Long hold of 4'b0101
        align_scan();
        n0 = n_del;
        keys[5] = 1'b1;
        wait_cycles(8 * SCAN);
        keys = '0;
        wait_cycles(4 * SCAN);
        check("hold_code0", 32'((n_del > n0) ? del_code[n0] : 4'hx), 32'h5);
`ifdef KEYPAD_REPEAT_EN
        check("rep_count", 32'((n_del - n0) >= 2), 32'd1);
        gap = ((n_del - n0) >= 2) ? (del_cycle[n0 + 1] - del_cycle[n0]) : -1;
        check("rep_gap", 32'(gap), 32'd48);
        check("rep_code1", 32'(((n_del - n0) >= 2) ? del_code[n0 + 1] : 4'hx), 32'h5);
`else
        check("hold_once", 32'(n_del - n0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
